// File: rtl/dwa_element_rotator.sv
// dwa_element_rotator: rotates the thermometer popcount onto a moving window of unit elements
module dwa_element_rotator #(
  parameter int therm_width = 8,
  parameter int ptr_width   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_valid,
  input  logic [therm_width-1:0] therm_in,
  input  logic                   dwa_bypass,
  output logic [therm_width-1:0] elem_out,
  output logic                   out_valid,
  output logic [ptr_width-1:0]   ptr,
  output logic                   bubble_err
);
  logic [therm_width-1:0]   r_elem;
  logic                     r_valid;
  logic [ptr_width-1:0]     r_ptr;
  logic                     r_bubble;
  logic [ptr_width:0]       w_cnt;
  logic [therm_width-1:0]   w_mask;
  logic [2*therm_width-1:0] w_dbl;
  logic [therm_width-1:0]   w_rot;
  logic [ptr_width:0]       w_sum;
  logic [ptr_width-1:0]     w_next;
  logic [therm_width-1:0]   w_inc;
  logic                     w_bubble;
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < therm_width; i++) w_cnt = w_cnt + (ptr_width+1)'(therm_in[i]);
  end
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < therm_width; i++) w_mask[i] = (ptr_width+1)'(i) < w_cnt;
  end
  // Rotate via a double-width shift so the wrap works for non-power-of-two widths
  assign w_dbl    = {{therm_width{1'b0}}, w_mask} << r_ptr;
  assign w_rot    = w_dbl[therm_width-1:0] | w_dbl[2*therm_width-1:therm_width];
  assign w_sum    = {1'b0, r_ptr} + w_cnt;
  assign w_next   = w_sum >= (ptr_width+1)'(therm_width) ?
                    ptr_width'(w_sum - (ptr_width+1)'(therm_width)) : ptr_width'(w_sum);
  // A legal code 2^N-1 has no bit in common with its successor
  assign w_inc    = therm_in + therm_width'(1);
  assign w_bubble = |(therm_in & w_inc);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_elem   <= '0;
      r_valid  <= 1'b0;
      r_ptr    <= '0;
      r_bubble <= 1'b0;
    end else begin
      r_valid <= sample_valid;
      if (sample_valid) begin
        r_elem   <= dwa_bypass ? therm_in : w_rot;
        r_ptr    <= dwa_bypass ? r_ptr : w_next;
        r_bubble <= w_bubble;
      end
    end
  end
  assign elem_out   = r_elem;
  assign out_valid  = r_valid;
  assign ptr        = r_ptr;
  assign bubble_err = r_bubble;
endmodule

// File: doc/dwa_element_rotator.md
# dwa_element_rotator

Data-weighted-averaging (DWA) stage that sits directly downstream of the binary-to-thermometer decoder in the DAC datapath. It takes the thermometer code for each sample, counts the active unit elements, and re-maps them onto a rotating window of physical elements, so every unit element is used equally often and static element mismatch is shaped out of band. Output is registered and drives the unit-element switch bank.

## Interface
- `therm_width`, 8: number of unit elements; any value ≥ 2, not required to be a power of two.
- `ptr_width`, 3: pointer width; must equal ceil(log2(therm_width)).
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `sample_valid`, in, 1: qualifies `therm_in` for one sample on this clock edge.
- `therm_in`, in, `therm_width`: thermometer code from the upstream decoder.
- `dwa_bypass`, in, 1: 1 = pass `therm_in` through unrotated.
- `elem_out`, out, `therm_width`: unit-element enables, registered.
- `out_valid`, out, 1: one-cycle pulse marking a new `elem_out`.
- `ptr`, out, `ptr_width`: current rotation pointer, i.e. the index of the next element to be used.
- `bubble_err`, out, 1: last accepted `therm_in` was not a legal thermometer code.

## Operation
- Reset (rst_n low, asynchronous): `elem_out`=0, `ptr`=0, `out_valid`=0, `bubble_err`=0, effective immediately without waiting for a clock edge.
- Edge with `sample_valid`=1 and `dwa_bypass`=0:
  - N = popcount(`therm_in`), range 0..`therm_width`.
  - `elem_out` gets exactly N bits set, at indices `ptr`, `ptr`+1, …, `ptr`+N−1, each taken mod `therm_width` (wrap from MSB to bit 0).
  - `ptr` is updated to (`ptr`+N) mod `therm_width`.
  - The sum is computed with `ptr_width`+1 bits. Reduce it by a single conditional subtract of `therm_width`; do not truncate the bits.
- N=0: `elem_out`=0 and `ptr` is unchanged.
- N=`therm_width`: `elem_out` is all ones and `ptr` is unchanged.
- Edge with `sample_valid`=1 and `dwa_bypass`=1: `elem_out`=`therm_in` verbatim and `ptr` holds.
- `bubble_err` is registered on every accepted sample, in both modes:
  - It is 1 when `therm_in` is not of the form 2^N−1.
  - It is cleared by the next legal sample.
  - A code with bubbles is still rotated using its popcount N.
- Edge with `sample_valid`=0: `elem_out`, `ptr` and `bubble_err` hold; `out_valid`=0.
- `dwa_bypass` is sampled only together with `sample_valid`. Toggling it does not reset `ptr`.

## Timing
- Latency is 1 cycle: the sample accepted at edge k appears on `elem_out` after edge k, with `out_valid`=1 for exactly that cycle.
- Throughput: one sample per clock; back-to-back `sample_valid` is supported.
- There is no backpressure. The downstream switch bank always accepts `elem_out`.
- `ptr` as seen by the bench after edge k is the post-update value, i.e. the start index for sample k+1.
- Reset asserted mid-stream: outputs clear asynchronously. The first sample accepted after `rst_n` deasserts starts at bit 0.
- The pointer update and rotation must close timing in one cycle at `therm_width` up to 16.
- All outputs come directly from flops; there is no combinational path from input to output.

## Test plan
All scenarios use `therm_width`=8 and `ptr_width`=3.
- **Reset:** pull `rst_n` low between edges → `elem_out`=0x00, `ptr`=0, `out_valid`=0 and `bubble_err`=0 immediately, before the next edge.
- **Wrap sequence:** three back-to-back samples of `therm_in`=0x07 → `elem_out`=0x07, then 0x38, then 0xC1; `ptr` steps 3, 6, 1; `out_valid` is high for 3 cycles.
- **Extremes:** from `ptr`=5:
  - `therm_in`=0xFF → `elem_out`=0xFF, `ptr` stays 5.
  - Next, `therm_in`=0x00 → `elem_out`=0x00, `ptr` stays 5.
  - Then one idle cycle → `out_valid`=0 and `elem_out` holds 0x00.
- **Bubble:** from `ptr`=6, `therm_in`=0x05 → N=2, `elem_out`=0xC0, `ptr`=0, `bubble_err`=1; next `therm_in`=0x01 → `elem_out`=0x01, `bubble_err`=0.
- **Bypass:** from `ptr`=4, `therm_in`=0x0F with `dwa_bypass`=1 → `elem_out`=0x0F, `ptr` stays 4; next sample 0x03 with `dwa_bypass`=0 → `elem_out`=0x30, `ptr`=6.
- **Reset mid-stream:** with `ptr`=5, pulse `rst_n` low → `ptr`=0 asynchronously; next `therm_in`=0x03 → `elem_out`=0x03.
